// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   WordWidth  - instruction / address word width (16)
//   OPC_HALT   - opcode in bits [15:12] that stops fetching
//   fetch_state_e - fetch FSM state encoding
package fetch_pkg;

    localparam int unsigned WordWidth = 16;
    localparam logic [3:0]  OPC_HALT  = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHold,
        StHalt,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// sat_counter: saturating up-counter with enable, cleared only by reset.
// Only needed by fetch_unit when FETCH_STALL_CNT_EN is defined, so the module
// is only compiled in that configuration.
//   clk   - clock
//   rst   - asynchronous active-high reset, clears the count
//   en    - count this cycle (ignored once saturated)
//   count - current count value
`ifdef FETCH_STALL_CNT_EN
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_d;
    logic [Width-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {Width{1'b1}})) begin
            count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 16-bit CPU.
// Reads the PC, fetches one word over a req/ack memory port, and holds it in a
// one-entry IF/ID buffer with a valid/ready handshake to decode.
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_cnt output.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   pc / pc_en          - current PC in; one-cycle PC write enable out
//   flush               - squash / redirect from execute (PC rewritten externally)
//   imem_req/addr       - memory request and byte address
//   imem_ack/rdata      - one-cycle acknowledge with instruction word
//   if_valid/instr/pc   - IF/ID buffer contents
//   id_ready            - decode accepts the buffered instruction
//   halted              - HALT fetched, no further requests until flush
//   stall_cnt           - cycles spent waiting on memory (optional)
module fetch_unit
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WordWidth-1:0] pc,
    output logic                 pc_en,
    input  logic                 flush,
    output logic                 imem_req,
    output logic [WordWidth-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WordWidth-1:0] imem_rdata,
    output logic                 if_valid,
    output logic [WordWidth-1:0] if_instr,
    output logic [WordWidth-1:0] if_pc,
    input  logic                 id_ready,
    output logic                 halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [WordWidth-1:0] stall_cnt
`endif
);

    fetch_state_e         state_d, state_q;
    logic [WordWidth-1:0] addr_d, addr_q;
    logic                 valid_d, valid_q;
    logic [WordWidth-1:0] instr_d, instr_q;
    logic [WordWidth-1:0] ipc_d, ipc_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        pc_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A flush here means the PC changes next cycle; wait for it.
                if (!flush) begin
                    addr_d  = pc;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (flush) begin
                    // Data arriving with the flush is dropped; otherwise the
                    // outstanding request must still be drained.
                    state_d = imem_ack ? StIdle : StDrop;
                end else if (imem_ack) begin
                    pc_en   = 1'b1;
                    instr_d = imem_rdata;
                    ipc_d   = addr_q;
                    valid_d = 1'b1;
                    if (imem_rdata[WordWidth-1 -: 4] == OPC_HALT) begin
                        state_d = StHalt;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (flush) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (id_ready) begin
                    // PC already advanced by the pc_en pulse at the ack.
                    valid_d = 1'b0;
                    addr_d  = pc;
                    state_d = StReq;
                end
            end
            StHalt: begin
                if (flush) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (id_ready) begin
                    valid_d = 1'b0;
                end
            end
            StDrop: begin
                if (!flush && imem_ack) begin
                    addr_d  = pc;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign imem_req  = (state_q == StReq) || (state_q == StDrop);
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = ipc_q;
    assign halted    = (state_q == StHalt);

`ifdef FETCH_STALL_CNT_EN
    logic stall_en;
    assign stall_en = imem_req && !imem_ack;

    sat_counter #(
        .Width(WordWidth)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (stall_en),
        .count(stall_cnt)
    );
`endif

endmodule
